// File: rtl/stack_ptr_bank_if.sv
// Control-side bundle for the stack pointer bank: strobes and bounds in,
// pointers and status out.
interface stack_ptr_bank_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_STACKS = 2
);
    logic [NUM_STACKS*WIDTH-1:0] base;
    logic [NUM_STACKS*WIDTH-1:0] limit;
    logic [NUM_STACKS-1:0]       push;
    logic [NUM_STACKS-1:0]       pop;
    logic [NUM_STACKS-1:0]       load;
    logic [WIDTH-1:0]            load_data;
    logic                        clear_fault;
    logic [NUM_STACKS*WIDTH-1:0] sp_out;
    logic [NUM_STACKS-1:0]       empty;
    logic [NUM_STACKS-1:0]       full;
    logic [NUM_STACKS-1:0]       overflow;
    logic [NUM_STACKS-1:0]       underflow;
    logic                        fault;

    modport master (
        output base, limit, push, pop, load, load_data, clear_fault,
        input  sp_out, empty, full, overflow, underflow, fault
    );

    modport slave (
        input  base, limit, push, pop, load, load_data, clear_fault,
        output sp_out, empty, full, overflow, underflow, fault
    );
endinterface

// File: rtl/stack_ptr_bank.sv
// Bank of independent downward-growing stack pointers with bounds checking,
// sticky overflow/underflow faults, direct load and replace-top.
module stack_ptr_bank #(
    parameter int WIDTH      = 16,
    parameter int NUM_STACKS = 2,
    parameter int STEP       = 2
) (
    input  logic               clk,
    input  logic               reset,
    stack_ptr_bank_if.slave    bus
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    // Full is evaluated one bit wider so that limit + STEP can never wrap.
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
        logic [WIDTH-1:0] base_i;
        logic [WIDTH-1:0] limit_i;
        logic [WIDTH-1:0] sp_q;
        logic [WIDTH-1:0] sp_d;
        logic             ovf_q;
        logic             unf_q;
        logic             ovf_set;
        logic             unf_set;
        logic             empty_i;
        logic             full_i;

        assign base_i  = bus.base[i*WIDTH +: WIDTH];
        assign limit_i = bus.limit[i*WIDTH +: WIDTH];
        assign empty_i = (sp_q >= base_i);
        assign full_i  = ({1'b0, sp_q} < ({1'b0, limit_i} + STEP_X));

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
            sp_d    = sp_q;
            ovf_set = 1'b0;
            unf_set = 1'b0;
            if (bus.load[i]) begin
                sp_d = bus.load_data;
            end else if (bus.push[i] && bus.pop[i]) begin
                unf_set = empty_i;
            end else if (bus.push[i]) begin
                if (full_i) ovf_set = 1'b1;
                else        sp_d    = sp_q - STEP_W;
            end else if (bus.pop[i]) begin
                if (empty_i) unf_set = 1'b1;
                else         sp_d    = sp_q + STEP_W;
            end
        end

        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (reset) begin
                sp_q  <= base_i;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                sp_q  <= sp_d;
                // A fault raised in the same cycle as clear_fault survives.
                ovf_q <= ovf_set | (ovf_q & ~bus.clear_fault);
                unf_q <= unf_set | (unf_q & ~bus.clear_fault);
            end
        end

        assign bus.sp_out[i*WIDTH +: WIDTH] = sp_q;
        assign bus.empty[i]                 = empty_i;
        assign bus.full[i]                  = full_i;
        assign bus.overflow[i]              = ovf_q;
        assign bus.underflow[i]             = unf_q;
    end

    assign bus.fault = (|bus.overflow) | (|bus.underflow);
endmodule

// File: tb/tb_stack_ptr_bank.sv
// Scoreboard bench for stack_ptr_bank: expected state is queued as each cycle
// of stimulus is driven and compared once the clock edge has been taken.
module tb_stack_ptr_bank;
    localparam int W = 16;
    localparam int N = 2;
    localparam int STEP = 2;
    localparam logic [W-1:0] BASE0  = 16'h0100;
    localparam logic [W-1:0] LIMIT0 = 16'h00F8;
    localparam logic [W-1:0] BASE1  = 16'h0200;
    localparam logic [W-1:0] LIMIT1 = 16'h01F0;

    typedef struct {
        string       tag;
        logic [W-1:0] sp0;
        logic [W-1:0] sp1;
        logic [1:0]  empty;
        logic [1:0]  full;
        logic [1:0]  ovf;
        logic [1:0]  unf;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    stack_ptr_bank_if #(.WIDTH(W), .NUM_STACKS(N)) bus ();

    stack_ptr_bank #(.WIDTH(W), .NUM_STACKS(N), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Status bits derived directly from the bounds written in the test plan.
    function automatic exp_t mk(input string tag, input logic [W-1:0] sp0, input logic [W-1:0] sp1,
                                input logic [1:0] ovf, input logic [1:0] unf);
        exp_t e;
        int unsigned s0 = sp0;
        int unsigned s1 = sp1;
        e.tag      = tag;
        e.sp0      = sp0;
        e.sp1      = sp1;
        e.empty[0] = (s0 >= 32'h0100);
        e.empty[1] = (s1 >= 32'h0200);
        e.full[0]  = (s0 < 32'h00F8 + STEP);
        e.full[1]  = (s1 < 32'h01F0 + STEP);
        e.ovf      = ovf;
        e.unf      = unf;
        e.fault    = (ovf != 2'b00) || (unf != 2'b00);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic cycle(input logic rst, input logic [1:0] push, input logic [1:0] pop,
                         input logic [1:0] load, input logic [W-1:0] ld, input logic clr,
                         input exp_t e);
        exp_t got;
        reset           = rst;
        bus.push        = push;
        bus.pop         = pop;
        bus.load        = load;
        bus.load_data   = ld;
        bus.clear_fault = clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({got.tag, ".sp0"},   32'(bus.sp_out[W-1:0]),   32'(got.sp0));
        check({got.tag, ".sp1"},   32'(bus.sp_out[2*W-1:W]), 32'(got.sp1));
        check({got.tag, ".empty"}, 32'(bus.empty),           32'(got.empty));
        check({got.tag, ".full"},  32'(bus.full),            32'(got.full));
        check({got.tag, ".ovf"},   32'(bus.overflow),        32'(got.ovf));
        check({got.tag, ".unf"},   32'(bus.underflow),       32'(got.unf));
        check({got.tag, ".fault"}, 32'(bus.fault),           32'(got.fault));
    endtask

    initial begin
        bus.base  = {BASE1, BASE0};
        bus.limit = {LIMIT1, LIMIT0};

        // Reset for two cycles.
        cycle(1, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("rst_a", 16'h0100, 16'h0200, 2'b00, 2'b00));
        cycle(1, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("rst_b", 16'h0100, 16'h0200, 2'b00, 2'b00));

        // Fill stack 0 down to its limit, then overflow it.
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("push1", 16'h00FE, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("push2", 16'h00FC, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("push3", 16'h00FA, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("push4", 16'h00F8, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("push5_ovf", 16'h00F8, 16'h0200, 2'b01, 2'b00));
        cycle(0, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("ovf_hold", 16'h00F8, 16'h0200, 2'b01, 2'b00));

        // Underflow on stack 1, clear, then clear racing a new underflow.
        cycle(1, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("rst_c", 16'h0100, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b00, 2'b10, 2'b00, 16'h0, 0, mk("pop1_unf", 16'h0100, 16'h0200, 2'b00, 2'b10));
        cycle(0, 2'b00, 2'b00, 2'b00, 16'h0, 1, mk("clear", 16'h0100, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b00, 2'b10, 2'b00, 16'h0, 1, mk("clear_vs_unf", 16'h0100, 16'h0200, 2'b00, 2'b10));

        // Replace-top and load-over-push on stack 0.
        cycle(1, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("rst_d", 16'h0100, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("pre_fe", 16'h00FE, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("pre_fc", 16'h00FC, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b01, 2'b00, 16'h0, 0, mk("replace_top", 16'h00FC, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b00, 2'b01, 16'h00F0, 0, mk("load_wins", 16'h00F0, 16'h0200, 2'b00, 2'b00));
        // Replace-top on an empty stack raises underflow.
        cycle(0, 2'b10, 2'b10, 2'b00, 16'h0, 0, mk("replace_empty", 16'h00F0, 16'h0200, 2'b00, 2'b10));
        // A load above base reads as empty.
        cycle(0, 2'b00, 2'b00, 2'b10, 16'h0300, 0, mk("load_above", 16'h00F0, 16'h0300, 2'b00, 2'b10));

        // Independent stacks: push 0 while popping 1.
        cycle(1, 2'b00, 2'b00, 2'b00, 16'h0, 0, mk("rst_e", 16'h0100, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b10, 2'b00, 2'b00, 16'h0, 0, mk("p1_1fe", 16'h0100, 16'h01FE, 2'b00, 2'b00));
        cycle(0, 2'b10, 2'b00, 2'b00, 16'h0, 0, mk("p1_1fc", 16'h0100, 16'h01FC, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b10, 2'b00, 16'h0, 0, mk("indep", 16'h00FE, 16'h01FE, 2'b00, 2'b00));

        // Build SP0=0x00FA with a fault pending, then reset against a push.
        cycle(0, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("to_fc", 16'h00FC, 16'h01FE, 2'b00, 2'b00));
        cycle(0, 2'b01, 2'b10, 2'b00, 16'h0, 0, mk("to_fa", 16'h00FA, 16'h0200, 2'b00, 2'b00));
        cycle(0, 2'b00, 2'b10, 2'b00, 16'h0, 0, mk("unf_pend", 16'h00FA, 16'h0200, 2'b00, 2'b10));
        cycle(1, 2'b01, 2'b00, 2'b00, 16'h0, 0, mk("rst_vs_push", 16'h0100, 16'h0200, 2'b00, 2'b00));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_ptr_bank.md
Name: stack_ptr_bank

Overview:
- Parametrised bank of hardware stack pointers for the JALA datapath.
- Generalises the fixed MSP/RSP pair to NUM_STACKS independent pointers with configurable width, step, base and limit.
- Adds bounds checking, sticky overflow/underflow faults, direct load and push/pop replace-top.
- Sits between the control unit (push/pop/load strobes) and the memory address muxes (SPOut).

Parameters:
WIDTH, 16, bit width of each pointer and address.
NUM_STACKS, 2, number of independent stacks (index 0 = MSP, 1 = RSP by convention).
STEP, 2, address increment per stack entry; must be 1..2^(WIDTH-1).

Ports:
CLK  input  1  system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Base  input  NUM_STACKS*WIDTH  per-stack empty address, slice i = bits [i*WIDTH +: WIDTH]; must be static while Reset is low.
Limit  input  NUM_STACKS*WIDTH  per-stack lowest legal pointer value; Limit_i < Base_i.
Push  input  NUM_STACKS  per-stack push strobe.
Pop  input  NUM_STACKS  per-stack pop strobe.
Load  input  NUM_STACKS  per-stack direct-write strobe.
LoadData  input  WIDTH  value written by Load; shared by all stacks.
ClearFault  input  1  clears all sticky fault bits.
SPOut  output  NUM_STACKS*WIDTH  registered pointer per stack; points at the current top entry.
Empty  output  NUM_STACKS  SP_i >= Base_i (unsigned).
Full  output  NUM_STACKS  SP_i < Limit_i + STEP, compared at WIDTH+1 bits.
Overflow  output  NUM_STACKS  sticky: push attempted while Full.
Underflow  output  NUM_STACKS  sticky: pop attempted while Empty.
Fault  output  1  OR of all Overflow and Underflow bits.

Behaviour:
- Reset (synchronous, active-high):
  - SP_i <= Base_i.
  - Overflow and Underflow <= 0.
  - Reset overrides all strobes, including mid-operation.
  - After reset: Empty = all 1, Full = 0, Fault = 0.
- Stacks grow downward with pre-decrement push:
  - Push: SP_i <= SP_i - STEP.
  - Pop: SP_i <= SP_i + STEP.
- Latency: SPOut updates one cycle after the strobe. Empty and Full are combinational from the registered SP and the Base/Limit inputs.
- Per-stack priority each cycle, stacks fully independent:
  1. Load_i: SP_i <= LoadData. No bounds check, no fault update; Push_i/Pop_i ignored.
  2. Push_i & Pop_i (replace-top):
     - SP_i unchanged.
     - If Empty_i, set Underflow_i; otherwise no flag change.
  3. Push_i only:
     - If Full_i, SP_i unchanged and Overflow_i <= 1.
     - Otherwise decrement.
  4. Pop_i only:
     - If Empty_i, SP_i unchanged and Underflow_i <= 1.
     - Otherwise increment.
  5. None: hold.
- Faults are sticky until Reset or ClearFault.
- ClearFault takes effect in the same cycle as a new fault event; the new event wins, so the bit stays 1.
- Arithmetic:
  - SP math is modulo 2^WIDTH; wrap can only occur after an out-of-range Load.
  - The Full comparison uses WIDTH+1 bits so that Limit + STEP cannot wrap.
- Loaded values outside [Limit_i, Base_i] are legal. Empty and Full follow the same unsigned formulas (e.g. SP above Base reads Empty = 1).
- NUM_STACKS = 1 must elaborate; no stack index may be hard-coded.

Test Plan:
- Setup for all scenarios: N=2, W=16, STEP=2, Base0=0x0100, Limit0=0x00F8, Base1=0x0200, Limit1=0x01F0.
- Reset for 2 cycles -> SPOut0=0x0100, SPOut1=0x0200, Empty=2'b11, Full=0, Fault=0.
- Push0 on 4 consecutive cycles -> SPOut0 = 0x00FE, 0x00FC, 0x00FA, 0x00F8; Full0=1 after the 4th push. 5th Push0 -> SPOut0 stays 0x00F8, Overflow0=1, Fault=1. SPOut1 unchanged throughout.
- From reset, Pop1 -> SPOut1 stays 0x0200, Underflow1=1. ClearFault for 1 cycle -> Underflow1=0, Fault=0. ClearFault and Pop1 in the same cycle -> Underflow1=1.
- SP0=0x00FC: Push0&Pop0 -> SPOut0 stays 0x00FC, no fault. Load0 with LoadData=0x00F0 and Push0 in the same cycle -> SPOut0=0x00F0, Full0=1, no Overflow0.
- Push0 and Pop1 in the same cycle with SP1=0x01FC -> SPOut0=0x00FE, SPOut1=0x01FE.
- Reset asserted in the same cycle as Push0 with SP0=0x00FA -> SPOut0=0x0100, all faults 0.
